// File: rtl/dyn_ind_pkg.sv
// Shared constants for the multiplexed 7-segment display driver:
// blank pattern, hex-to-segment table (active-low gfedcba) and anode helper.
package dyn_ind_pkg;

    localparam int MAX_W = 32;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Active-low one-hot anode pattern for a digit index; callers truncate to their width.
    function automatic logic [MAX_W-1:0] anode_pat(input logic [4:0] idx);
        return ~(MAX_W'(1) << idx);
    endfunction

endpackage

// File: rtl/dyn_ind_scan_seg_hex_lut.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module seg_hex_lut
    import dyn_ind_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/dyn_ind_scan.sv
// Dynamic-indication driver for a multiplexed common-anode 7-segment display.
// Scans DIGITS digits, DIV clocks per digit; input data is snapshotted once per
// frame so a digit never tears mid-frame. Segments and anodes change on the same edge.
// Optional brightness PWM on the anodes: define DYN_IND_DIM_EN.
module dyn_ind_scan
    import dyn_ind_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4,
    parameter int DIV    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
`ifdef DYN_IND_DIM_EN
    input  logic [3:0]            bright_i,
`endif
    output logic [6:0]            to_hex,
    output logic                  to_hex_dp,
    output logic [WIDTH-1:0]      to_hex_ans
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    if (DIV < 1) begin : g_div_chk
        $error("dyn_ind_scan: DIV must be 1 or more");
    end
    if (DIGITS < 1 || DIGITS > WIDTH || WIDTH > MAX_W) begin : g_dig_chk
        $error("dyn_ind_scan: need 1 <= DIGITS <= WIDTH <= 32");
    end

    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         idx_d;
    logic [WIDTH-1:0]      slot_ans_q;
    logic [WIDTH-1:0]      ans_d;
    logic [4*DIGITS-1:0]   snap_digits_q;
    logic [DIGITS-1:0]     snap_dp_q;
    logic [DIGITS-1:0]     snap_blank_q;
    logic [4*DIGITS-1:0]   cur_digits;
    logic [DIGITS-1:0]     cur_dp;
    logic [DIGITS-1:0]     cur_blank;
    logic [3:0]            nib_d;
    logic                  dp_sel;
    logic                  blk_sel;
    logic [6:0]            seg_d;
    logic                  tick;
    logic                  frame_start;

    assign tick        = en && (cnt_q == CNT_LAST);
    assign idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    assign frame_start = (idx_d == '0);

    // At a frame start show the live inputs, which are the same values being snapshotted.
    assign cur_digits = frame_start ? digits_i : snap_digits_q;
    assign cur_dp     = frame_start ? dp_i     : snap_dp_q;
    assign cur_blank  = frame_start ? blank_i  : snap_blank_q;

    // Select the nibble, dp and blank bits of the digit about to be shown.
    always_comb begin
        nib_d   = '0;
        dp_sel  = 1'b0;
        blk_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                nib_d   = cur_digits[4*k +: 4];
                dp_sel  = cur_dp[k];
                blk_sel = cur_blank[k];
            end
        end
    end

    seg_hex_lut u_lut (
        .nib_i (nib_d),
        .seg_o (seg_d)
    );

    assign ans_d = WIDTH'(anode_pat(5'(idx_d)));

    // Prescaler, slot index, per-frame snapshot and registered segment/anode outputs.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q      <= '0;
            idx_q      <= IDX_LAST;
            to_hex     <= SEG_BLANK;
            to_hex_dp  <= 1'b1;
            slot_ans_q <= '1;
            if (rst) begin
                snap_digits_q <= '0;
                snap_dp_q     <= '0;
                snap_blank_q  <= '0;
            end
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                idx_q      <= idx_d;
                to_hex     <= blk_sel ? SEG_BLANK : seg_d;
                to_hex_dp  <= ~(dp_sel & ~blk_sel);
                slot_ans_q <= ans_d;
                if (frame_start) begin
                    snap_digits_q <= digits_i;
                    snap_dp_q     <= dp_i;
                    snap_blank_q  <= blank_i;
                end
            end
        end
    end

`ifdef DYN_IND_DIM_EN
    logic [3:0] pwm_q;

    // Free-running PWM phase; the anode is gated in a flop so the pin stays glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q      <= '0;
            to_hex_ans <= '1;
        end else if (!en) begin
            to_hex_ans <= '1;
        end else begin
            pwm_q      <= pwm_q + 4'd1;
            to_hex_ans <= (pwm_q <= bright_i) ? (tick ? ans_d : slot_ans_q) : '1;
        end
    end
`else
    assign to_hex_ans = slot_ans_q;
`endif

endmodule

// File: tb/tb_dyn_ind_scan.sv
// Scoreboard bench for dyn_ind_scan: expected outputs are queued with the
// cycle they must appear on and compared on the falling edge.
module tb_dyn_ind_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // DUT A: W8 D4 DIV4
    logic        rst_a, en_a;
    logic [15:0] digits_a;
    logic [3:0]  dp_a, blank_a;
    logic [6:0]  hex_a;
    logic        hdp_a;
    logic [7:0]  ans_a;

    // DUT B: W8 D3 DIV1
    logic        rst_b, en_b;
    logic [11:0] digits_b;
    logic [2:0]  dp_b, blank_b;
    logic [6:0]  hex_b;
    logic        hdp_b;
    logic [7:0]  ans_b;
    logic        b_live = 1'b0;

`ifdef DYN_IND_DIM_EN
    logic [3:0]  bright_full = 4'd15;
    logic        rst_c;
    logic        en_c = 1'b1;
    logic [3:0]  bright_c = 4'd3;
    logic [15:0] digits_c = 16'h1234;
    logic [3:0]  dp_c = 4'd0;
    logic [3:0]  blank_c = 4'd0;
    logic [6:0]  hex_c;
    logic        hdp_c;
    logic [7:0]  ans_c;
`endif

    dyn_ind_scan #(.WIDTH(8), .DIGITS(4), .DIV(4)) u_dut_a (
        .clk(clk), .rst(rst_a), .en(en_a),
        .digits_i(digits_a), .dp_i(dp_a), .blank_i(blank_a),
`ifdef DYN_IND_DIM_EN
        .bright_i(bright_full),
`endif
        .to_hex(hex_a), .to_hex_dp(hdp_a), .to_hex_ans(ans_a)
    );

    dyn_ind_scan #(.WIDTH(8), .DIGITS(3), .DIV(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en_b),
        .digits_i(digits_b), .dp_i(dp_b), .blank_i(blank_b),
`ifdef DYN_IND_DIM_EN
        .bright_i(bright_full),
`endif
        .to_hex(hex_b), .to_hex_dp(hdp_b), .to_hex_ans(ans_b)
    );

`ifdef DYN_IND_DIM_EN
    dyn_ind_scan #(.WIDTH(8), .DIGITS(4), .DIV(64)) u_dut_c (
        .clk(clk), .rst(rst_c), .en(en_c),
        .digits_i(digits_c), .dp_i(dp_c), .blank_i(blank_c),
        .bright_i(bright_c),
        .to_hex(hex_c), .to_hex_dp(hdp_c), .to_hex_ans(ans_c)
    );
`endif

    typedef struct {
        int         cyc;
        int         dut;
        logic [7:0] ans;
        logic [6:0] hex;
        logic       dp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    task automatic push(input int c, input int d, input logic [7:0] a,
                        input logic [6:0] h, input logic p, input string t);
        exp_t e;
        e.cyc = c; e.dut = d; e.ans = a; e.hex = h; e.dp = p; e.tag = t;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Compare every expectation that is due on this cycle; report any that were skipped.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                chk({e.tag, "_late"}, cyc, e.cyc);
            end else if (e.dut == 0) begin
                chk({e.tag, "_ans"}, ans_a, e.ans);
                chk({e.tag, "_hex"}, hex_a, e.hex);
                chk({e.tag, "_dp"},  hdp_a, e.dp);
            end else begin
                chk({e.tag, "_ans"}, ans_b, e.ans);
                chk({e.tag, "_hex"}, hex_b, e.hex);
                chk({e.tag, "_dp"},  hdp_b, e.dp);
            end
        end
        if (b_live) chk("b_hi_off", ans_b[7:3], 5'h1F);
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "watchdog");
    end

    int r, s;

    initial begin
        rst_a = 1'b1; en_a = 1'b1; digits_a = 16'h1234; dp_a = '0; blank_a = '0;
        rst_b = 1'b1; en_b = 1'b1; digits_b = 12'h567; dp_b = '0; blank_b = '0;
`ifdef DYN_IND_DIM_EN
        rst_c = 1'b1;
`endif
        repeat (3) @(negedge clk);
        b_live = 1'b1;

        // Plan 1: basic scan and latency
        r = cyc;
        rst_a = 1'b0;
        push(r+1,  0, 8'hFF, 7'h7F, 1'b1, "rst_state");
        push(r+3,  0, 8'hFF, 7'h7F, 1'b1, "pre_tick");
        push(r+4,  0, 8'hFE, 7'h19, 1'b1, "t1_d0");
        push(r+6,  0, 8'hFE, 7'h19, 1'b1, "t1_hold");
        push(r+8,  0, 8'hFD, 7'h30, 1'b1, "t1_d1");
        push(r+12, 0, 8'hFB, 7'h24, 1'b1, "t1_d2");
        push(r+16, 0, 8'hF7, 7'h79, 1'b1, "t1_d3");
        push(r+20, 0, 8'hFE, 7'h19, 1'b1, "t1_wrap");
        push(r+24, 0, 8'hFD, 7'h30, 1'b1, "t2_d1");

        // Plan 2: mid-frame change is deferred to the next frame
        wait_to(r+25);
        digits_a = 16'hABCD;
        push(r+28, 0, 8'hFB, 7'h24, 1'b1, "t2_old2");
        push(r+32, 0, 8'hF7, 7'h79, 1'b1, "t2_old3");
        push(r+36, 0, 8'hFE, 7'h21, 1'b1, "t2_nD");
        push(r+40, 0, 8'hFD, 7'h46, 1'b1, "t2_nC");
        push(r+44, 0, 8'hFB, 7'h03, 1'b1, "t2_nB");
        push(r+48, 0, 8'hF7, 7'h08, 1'b1, "t2_nA");

        // Plan 3: blanking and decimal points
        wait_to(r+49);
        blank_a = 4'b0100; dp_a = 4'b0101;
        push(r+52, 0, 8'hFE, 7'h21, 1'b0, "t3_d0dp");
        push(r+56, 0, 8'hFD, 7'h46, 1'b1, "t3_d1");
        push(r+60, 0, 8'hFB, 7'h7F, 1'b1, "t3_d2blk");
        push(r+64, 0, 8'hF7, 7'h08, 1'b1, "t3_d3");

        // Plan 4: enable dropped mid-slot, then restored
        wait_to(r+66);
        en_a = 1'b0;
        push(r+67, 0, 8'hFF, 7'h7F, 1'b1, "t4_off");
        push(r+70, 0, 8'hFF, 7'h7F, 1'b1, "t4_off_hold");
        wait_to(r+70);
        en_a = 1'b1;
        push(r+73, 0, 8'hFF, 7'h7F, 1'b1, "t4_pre");
        push(r+74, 0, 8'hFE, 7'h21, 1'b0, "t4_d0");
        push(r+78, 0, 8'hFD, 7'h46, 1'b1, "t4_d1");
        wait_to(r+80);

        // Plan 5: DIV=1, DIGITS=3, reset pulse mid-scan
        s = cyc;
        rst_b = 1'b0;
        push(s+1, 1, 8'hFE, 7'h78, 1'b1, "t5_d0");
        push(s+2, 1, 8'hFD, 7'h02, 1'b1, "t5_d1");
        push(s+3, 1, 8'hFB, 7'h12, 1'b1, "t5_d2");
        push(s+4, 1, 8'hFE, 7'h78, 1'b1, "t5_wrap");
        push(s+5, 1, 8'hFD, 7'h02, 1'b1, "t5_d1b");
        wait_to(s+5);
        rst_b = 1'b1;
        push(s+6, 1, 8'hFF, 7'h7F, 1'b1, "t5_rst");
        wait_to(s+6);
        rst_b = 1'b0;
        push(s+7, 1, 8'hFE, 7'h78, 1'b1, "t5_rel_d0");
        push(s+8, 1, 8'hFD, 7'h02, 1'b1, "t5_rel_d1");
        wait_to(s+10);

`ifdef DYN_IND_DIM_EN
        // Plan 6: bright=3 -> anode low 4 of every 16 cycles
        begin
            int t, lows;
            t = cyc;
            rst_c = 1'b0;
            wait_to(t+69);
            lows = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (ans_c != 8'hFF) begin
                    lows++;
                    chk("t6_ans_val", ans_c, 8'hFE);
                end
            end
            chk("t6_duty", lows, 4);
        end
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
